// File: rtl/rs485_uart_rx_fifo.sv
// RS485 UART receive path: synchroniser, 16x oversampled 8N1 receiver with
// majority-vote bit decisions, and a first-word-fall-through byte FIFO
// presented on a valid/ready handshake.
module rs485_uart_rx_fifo #(
    parameter int unsigned BAUD_DIV    = 54,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk_ik,
    input  logic                          rstn_ia,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          busy_o,
    output logic                          framing_err_o,
    output logic                          overrun_err_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Line synchroniser and edge history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx_sync_c;

    assign rx_sync_c = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous line into clk_ik; idle level is high.
    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_prev_q <= rx_sync_c;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [BAUD_W-1:0]   baud_cnt_q;
    logic                tick_c;
    logic                start_edge_c;

    assign tick_c       = (baud_cnt_q == BAUD_W'(BAUD_DIV - 1));
    assign start_edge_c = (state_q == S_IDLE) && rx_prev_q && !rx_sync_c;

    // Free-running divider, realigned to the start edge of each frame.
    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            baud_cnt_q <= '0;
        end else if (start_edge_c || tick_c) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [3:0] os_cnt_q;
    logic [2:0] bit_idx_q;
    logic       smp7_q;
    logic       smp8_q;
    logic [7:0] shift_q;
    logic       busy_q;
    logic       push_q;
    logic       framing_err_q;
    logic       maj_c;
    logic       decide_c;

    assign maj_c    = (smp7_q & smp8_q) | (smp7_q & rx_sync_c) | (smp8_q & rx_sync_c);
    assign decide_c = tick_c && (os_cnt_q == 4'd9);

    // Frame sequencing; bit values are the 2-of-3 vote of ticks 7, 8, 9.
    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            state_q       <= S_WAIT_IDLE;
            os_cnt_q      <= '0;
            bit_idx_q     <= '0;
            smp7_q        <= 1'b1;
            smp8_q        <= 1'b1;
            shift_q       <= '0;
            busy_q        <= 1'b0;
            push_q        <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            push_q        <= 1'b0;
            framing_err_q <= 1'b0;
            case (state_q)
                S_WAIT_IDLE: begin
                    busy_q <= 1'b0;
                    if (!rx_sync_c) begin
                        os_cnt_q <= '0;
                    end else if (tick_c) begin
                        if (os_cnt_q == 4'd15) begin
                            os_cnt_q <= '0;
                            state_q  <= S_IDLE;
                        end else begin
                            os_cnt_q <= os_cnt_q + 4'd1;
                        end
                    end
                end
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start_edge_c) begin
                        os_cnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START, S_DATA, S_STOP: begin
                    if (tick_c) begin
                        os_cnt_q <= os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd7) smp7_q <= rx_sync_c;
                        if (os_cnt_q == 4'd8) smp8_q <= rx_sync_c;
                    end
                    if (decide_c) begin
                        if (state_q == S_START) begin
                            if (!maj_c) begin
                                bit_idx_q <= '0;
                                state_q   <= S_DATA;
                            end else begin
                                // False start: glitch rather than a real start bit.
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else if (state_q == S_DATA) begin
                            shift_q <= {maj_c, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_q <= S_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            busy_q <= 1'b0;
                            if (maj_c) begin
                                push_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                // Lost framing: resync only after a full idle bit.
                                framing_err_q <= 1'b1;
                                os_cnt_q      <= '0;
                                state_q       <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_WAIT_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;
    logic             overrun_q;
    logic             pop_c;
    logic             full_c;
    logic             push_ok_c;

    assign pop_c     = valid_q && ready_i;
    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_ok_c = push_q && (!full_c || pop_c);

    // Occupancy update; a push and pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers, occupancy and overrun flag.
    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q   <= count_d;
            valid_q   <= (count_d != '0);
            overrun_q <= push_q && !push_ok_c;
        end
    end

    assign data_o        = mem_q[rd_ptr_q];
    assign valid_o       = valid_q;
    assign fill_o        = count_q;
    assign busy_o        = busy_q;
    assign framing_err_o = framing_err_q;
    assign overrun_err_o = overrun_q;

endmodule

// File: tb/tb_rs485_uart_rx_fifo.sv
// Directed bench for rs485_uart_rx_fifo. A reduced divider keeps the frame
// count tractable: BAUD_DIV = 6 gives a 96-clock bit period.
module tb_rs485_uart_rx_fifo;

    localparam int unsigned BAUD_DIV   = 6;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned BIT        = BAUD_DIV * 16;

    logic       clk_ik  = 1'b0;
    logic       rstn_ia = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [4:0] fill_o;
    logic       busy_o;
    logic       framing_err_o;
    logic       overrun_err_o;

    rs485_uart_rx_fifo #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk_ik       (clk_ik),
        .rstn_ia      (rstn_ia),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .fill_o       (fill_o),
        .busy_o       (busy_o),
        .framing_err_o(framing_err_o),
        .overrun_err_o(overrun_err_o)
    );

    always #5 clk_ik = ~clk_ik;

    // Pulse counters and record of every accepted pop.
    int         fr_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] popq[$];

    always @(posedge clk_ik) begin
        if (framing_err_o) fr_cnt <= fr_cnt + 1;
        if (overrun_err_o) ov_cnt <= ov_cnt + 1;
        if (valid_o && ready_i) popq.push_back(data_o);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_line(input logic v, input int unsigned n);
        rx_i = v;
        repeat (n) @(negedge clk_ik);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk_ik);
        hold_line(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold_line(b[i], BIT);
        hold_line(stop, BIT);
        rx_i = 1'b1;
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        @(negedge clk_ik);
        ready_i = 1'b0;
        repeat (2) @(negedge clk_ik);
    endtask

    int         f0;
    int         o0;
    logic [7:0] b96;

    initial begin
        // Reset state
        repeat (5) @(negedge clk_ik);
        check("rst_data",  32'(data_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_fill",  32'(fill_o), 32'h0);
        check("rst_busy",  32'(busy_o), 32'h0);
        check("rst_ferr",  32'(framing_err_o), 32'h0);
        check("rst_oerr",  32'(overrun_err_o), 32'h0);
        rstn_ia = 1'b1;
        repeat (2 * BIT) @(negedge clk_ik);

        // 1: single byte 0xA5, consumer stalled
        f0 = fr_cnt; o0 = ov_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk_ik);
        check("t1_valid", 32'(valid_o), 32'h1);
        check("t1_data",  32'(data_o), 32'hA5);
        check("t1_fill",  32'(fill_o), 32'h1);
        check("t1_busy",  32'(busy_o), 32'h0);
        repeat (50) @(negedge clk_ik);
        check("t1_data_hold", 32'(data_o), 32'hA5);
        check("t1_ferr", 32'(fr_cnt - f0), 32'h0);
        check("t1_oerr", 32'(ov_cnt - o0), 32'h0);
        pop_one();
        check("t1_npop", 32'(popq.size()), 32'd1);
        check("t1_pop0", 32'(popq[0]), 32'hA5);
        check("t1_valid_after", 32'(valid_o), 32'h0);

        // 2: back-to-back bytes, consumer always ready
        ready_i = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clk_ik);
        check("t2_npop", 32'(popq.size()), 32'd4);
        check("t2_pop1", 32'(popq[1]), 32'h00);
        check("t2_pop2", 32'(popq[2]), 32'hFF);
        check("t2_pop3", 32'(popq[3]), 32'h55);
        check("t2_fill", 32'(fill_o), 32'h0);
        check("t2_valid", 32'(valid_o), 32'h0);

        // 3: 300 ns glitch on an idle line
        f0 = fr_cnt; o0 = ov_cnt;
        @(negedge clk_ik);
        hold_line(1'b0, 10);
        check("t3_busy_rise", 32'(busy_o), 32'h1);
        hold_line(1'b0, 20);
        hold_line(1'b1, BIT);
        check("t3_busy_fall", 32'(busy_o), 32'h0);
        check("t3_fill", 32'(fill_o), 32'h0);
        check("t3_npop", 32'(popq.size()), 32'd4);
        check("t3_ferr", 32'(fr_cnt - f0), 32'h0);
        check("t3_oerr", 32'(ov_cnt - o0), 32'h0);

        // 4: framing error on 0x3C, recovery, then 0x81
        ready_i = 1'b0;
        f0 = fr_cnt; o0 = ov_cnt;
        send_byte(8'h3C, 1'b0);
        hold_line(1'b1, 2 * BIT);
        send_byte(8'h81, 1'b1);
        repeat (4) @(negedge clk_ik);
        check("t4_ferr", 32'(fr_cnt - f0), 32'h1);
        check("t4_oerr", 32'(ov_cnt - o0), 32'h0);
        check("t4_fill", 32'(fill_o), 32'h1);
        check("t4_data", 32'(data_o), 32'h81);
        pop_one();
        check("t4_npop", 32'(popq.size()), 32'd5);
        check("t4_pop", 32'(popq[4]), 32'h81);

        // 5: 17 bytes into a 16-deep FIFO
        f0 = fr_cnt; o0 = ov_cnt;
        for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1);
        repeat (4) @(negedge clk_ik);
        check("t5_fill", 32'(fill_o), 32'd16);
        check("t5_valid", 32'(valid_o), 32'h1);
        check("t5_head", 32'(data_o), 32'h01);
        check("t5_oerr", 32'(ov_cnt - o0), 32'h1);
        check("t5_ferr", 32'(fr_cnt - f0), 32'h0);
        ready_i = 1'b1;
        repeat (20) @(negedge clk_ik);
        ready_i = 1'b0;
        check("t5_npop", 32'(popq.size()), 32'd21);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t5_pop%0d", k), 32'(popq[5 + k]), 32'(k + 1));
        end
        check("t5_fill_end", 32'(fill_o), 32'h0);

        // 6: reset during bit 4 of 0x96, then a clean 0x42
        f0 = fr_cnt; o0 = ov_cnt;
        b96 = 8'h96;
        @(negedge clk_ik);
        hold_line(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold_line(b96[i], BIT);
        hold_line(b96[4], BIT / 2);
        rstn_ia = 1'b0;
        hold_line(b96[4], 3);
        check("t6_rst_fill", 32'(fill_o), 32'h0);
        check("t6_rst_valid", 32'(valid_o), 32'h0);
        check("t6_rst_busy", 32'(busy_o), 32'h0);
        rstn_ia = 1'b1;
        hold_line(b96[4], BIT / 2 - 3);
        for (int i = 5; i < 8; i++) hold_line(b96[i], BIT);
        hold_line(1'b1, BIT);
        hold_line(1'b1, BIT);
        check("t6_tail_fill", 32'(fill_o), 32'h0);
        check("t6_tail_valid", 32'(valid_o), 32'h0);
        send_byte(8'h42, 1'b1);
        repeat (4) @(negedge clk_ik);
        check("t6_fill", 32'(fill_o), 32'h1);
        check("t6_data", 32'(data_o), 32'h42);
        check("t6_ferr", 32'(fr_cnt - f0), 32'h0);
        check("t6_oerr", 32'(ov_cnt - o0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
